// File: rtl/keepalive_gen_if.sv
// rtl/keepalive_gen_if.sv - stream bundle (tdata/tvalid/tlast/tready) for keepalive_gen
//
// Purpose: groups one stream link's handshake signals.
// Signals:
//   tdata  [DW-1:0]  beat payload, source -> sink
//   tvalid           beat valid, source -> sink
//   tlast            end of packet, source -> sink
//   tready           sink can accept, sink -> source
// Modports: master = stream source, slave = stream sink.
interface keepalive_gen_if #(
  parameter int DW = 512
) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/keepalive_gen.sv
// rtl/keepalive_gen.sv - idle-link keepalive packet generator merged into a user stream
//
// Purpose: forwards a user stream with zero latency and, after PERIOD_CYCLES
// idle cycles outside a packet, injects a KA_BEATS-beat keepalive packet.
// Ports:
//   clk        clock, rising edge
//   resetn     synchronous active-low reset
//   enable     1 = keepalive generation permitted
//   s_axis     user stream in (slave modport)
//   m_axis     merged stream out (master modport)
//   ka_count   completed keepalive packets, wraps modulo 2^32
module keepalive_gen #(
  parameter int DW            = 512,
  parameter int PERIOD_CYCLES = 332265625,
  parameter int KA_BEATS      = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  keepalive_gen_if.slave        s_axis,
  keepalive_gen_if.master       m_axis,
  output logic [31:0]           ka_count
);

  localparam logic [31:0] RELOAD  = 32'(PERIOD_CYCLES - 1);
  localparam logic [7:0]  KA_LAST = 8'(KA_BEATS - 1);
  localparam logic [31:0] MAGIC   = 32'h4B41_4C56;

  typedef enum logic {ST_PASS, ST_KA} state_t;

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        in_packet_q, in_packet_d;
  logic [7:0]  beat_q, beat_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] ka_count_q, ka_count_d;

  logic [DW-1:0] ka_data;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          s_tready;
  logic          hs;

  // Keepalive payload depends only on registered beat/seq, so it is
  // stable while the sink back-pressures.
  always_comb begin
    ka_data = '0;
    if (beat_q == 8'd0) begin
      ka_data[31:0]  = MAGIC;
      ka_data[63:32] = seq_q;
    end else begin
      ka_data[31:0] = {24'd0, beat_q};
    end
  end

  // Output mux: bypass in PASS, generator in KA, quiet while in reset.
  always_comb begin
    m_tdata  = s_axis.tdata;
    m_tlast  = s_axis.tlast;
    m_tvalid = s_axis.tvalid;
    s_tready = m_axis.tready;
    if (!resetn) begin
      m_tvalid = 1'b0;
      s_tready = 1'b0;
    end else if (state_q == ST_KA) begin
      m_tdata  = ka_data;
      m_tlast  = (beat_q == KA_LAST);
      m_tvalid = 1'b1;
      s_tready = 1'b0;
    end
  end

  assign m_axis.tdata  = m_tdata;
  assign m_axis.tvalid = m_tvalid;
  assign m_axis.tlast  = m_tlast;
  assign s_axis.tready = s_tready;
  assign ka_count      = ka_count_q;

  assign hs = m_tvalid & m_axis.tready;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    in_packet_d = in_packet_q;
    beat_d      = beat_q;
    seq_d       = seq_q;
    ka_count_d  = ka_count_q;

    // Idle timer counts down from the last handshake; enable=0 parks it full.
    if (!enable || hs) begin
      timer_d = RELOAD;
    end else if (timer_q != 32'd0) begin
      timer_d = timer_q - 32'd1;
    end

    case (state_q)
      ST_PASS: begin
        if (hs) begin
          in_packet_d = ~s_axis.tlast;
        end
        // A pending user beat wins over the keepalive on the expiry cycle.
        if (timer_q == 32'd0 && enable && !in_packet_q && !s_axis.tvalid) begin
          state_d = ST_KA;
        end
      end
      ST_KA: begin
        if (hs) begin
          if (beat_q == KA_LAST) begin
            beat_d     = 8'd0;
            seq_d      = seq_q + 32'd1;
            ka_count_d = ka_count_q + 32'd1;
            state_d    = ST_PASS;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_PASS;
      timer_q     <= RELOAD;
      in_packet_q <= 1'b0;
      beat_q      <= 8'd0;
      seq_q       <= 32'd0;
      ka_count_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      in_packet_q <= in_packet_d;
      beat_q      <= beat_d;
      seq_q       <= seq_d;
      ka_count_q  <= ka_count_d;
    end
  end

endmodule

// File: tb/tb_keepalive_gen.sv
// tb/tb_keepalive_gen.sv - randomized self-checking bench for keepalive_gen
module tb_keepalive_gen;
  localparam int DW = 512;
  localparam int P  = 16;
  localparam int KB = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] ka_count;

  keepalive_gen_if #(.DW(DW)) s_axis ();
  keepalive_gen_if #(.DW(DW)) m_axis ();

  keepalive_gen #(.DW(DW), .PERIOD_CYCLES(P), .KA_BEATS(KB)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .enable  (enable),
    .s_axis  (s_axis),
    .m_axis  (m_axis),
    .ka_count(ka_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: idle = cycles since last handshake/reset/enable-low.
  bit          mdl_in_ka;
  int          mdl_beat;
  int          mdl_idle;
  bit          mdl_in_pkt;
  logic [31:0] mdl_seq;
  logic [31:0] mdl_cnt;
  bit          last_tvalid;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ka_word(input int beat, input logic [31:0] seq);
    logic [DW-1:0] w;
    w = '0;
    if (beat == 0) begin
      w[31:0]  = 32'h4B414C56;
      w[63:32] = seq;
    end else begin
      w[31:0] = 32'(beat);
    end
    return w;
  endfunction

  task automatic check_outputs();
    logic          exp_v, exp_r, exp_l;
    logic [DW-1:0] exp_d;
    exp_v = !resetn ? 1'b0 : (mdl_in_ka ? 1'b1 : s_axis.tvalid);
    exp_r = !resetn ? 1'b0 : (mdl_in_ka ? 1'b0 : m_axis.tready);
    check("m_tvalid", DW'(m_axis.tvalid), DW'(exp_v));
    check("s_tready", DW'(s_axis.tready), DW'(exp_r));
    check("ka_count", DW'(ka_count), DW'(mdl_cnt));
    if (resetn && exp_v) begin
      exp_d = mdl_in_ka ? ka_word(mdl_beat, mdl_seq) : s_axis.tdata;
      exp_l = mdl_in_ka ? (mdl_beat == KB - 1) : s_axis.tlast;
      check("m_tdata", m_axis.tdata, exp_d);
      check("m_tlast", DW'(m_axis.tlast), DW'(exp_l));
    end
    last_tvalid = m_axis.tvalid;
  endtask

  task automatic model_update();
    bit v, hs, start;
    if (!resetn) begin
      mdl_in_ka = 0; mdl_beat = 0; mdl_idle = 0; mdl_in_pkt = 0;
      mdl_seq = '0; mdl_cnt = '0;
      return;
    end
    v  = mdl_in_ka ? 1'b1 : s_axis.tvalid;
    hs = v && m_axis.tready;
    start = 0;
    if (mdl_in_ka) begin
      if (hs) begin
        if (mdl_beat == KB - 1) begin
          mdl_in_ka = 0; mdl_beat = 0;
          mdl_seq = mdl_seq + 1; mdl_cnt = mdl_cnt + 1;
        end else begin
          mdl_beat++;
        end
      end
    end else begin
      start = (mdl_idle >= P - 1) && enable && !mdl_in_pkt && !s_axis.tvalid;
      if (hs) mdl_in_pkt = !s_axis.tlast;
      if (start) mdl_in_ka = 1;
    end
    if (!enable || hs) mdl_idle = 0;
    else if (mdl_idle < P) mdl_idle++;
  endtask

  task automatic cycle(input bit rn, input bit en, input bit sv, input bit sl, input bit rdy);
    @(negedge clk);
    resetn          = rn;
    enable          = en;
    s_axis.tvalid   = sv;
    s_axis.tlast    = sl;
    m_axis.tready   = rdy;
    for (int i = 0; i < DW / 32; i++) s_axis.tdata[i*32 +: 32] = $urandom;
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
  endtask

  initial begin
    int first;
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b0;
    mdl_in_ka = 0; mdl_beat = 0; mdl_idle = 0; mdl_in_pkt = 0;
    mdl_seq = '0; mdl_cnt = '0;

    // Reset with busy inputs: outputs must stay quiet.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Idle after reset: keepalive appears on cycle 16 of the released run.
    first = -1;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      if (last_tvalid && first < 0) first = c;
    end
    check("ka_latency", DW'(first), DW'(16));
    check("ka_count_first", DW'(ka_count), DW'(1));

    // Run into the next keepalive and reset during its second beat.
    for (int c = 0; c < 40 && !(mdl_in_ka && mdl_beat == 1); c++)
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("reached_beat1", DW'(mdl_in_ka && mdl_beat == 1), DW'(1));
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("ka_count_after_rst", DW'(ka_count), DW'(0));

    // Randomized phases of traffic density, back-pressure, enable and rare resets.
    for (int ph = 0; ph < 100; ph++) begin
      int tmode, rmode, len, tprob, rprob;
      bit pen;
      tmode = $urandom_range(0, 3);
      rmode = $urandom_range(0, 3);
      pen   = ($urandom_range(0, 4) != 0);
      len   = $urandom_range(40, 80);
      tprob = (tmode == 0) ? 0 : (tmode == 1) ? 10 : (tmode == 2) ? 60 : 100;
      rprob = (rmode == 0) ? 100 : (rmode == 1) ? 80 : (rmode == 2) ? 50 : 20;
      for (int c = 0; c < len; c++) begin
        cycle($urandom_range(0, 399) != 0, pen,
              $urandom_range(0, 99) < tprob,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 99) < rprob);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
